// File: rtl/pdh_pkg.sv
// Shared definitions for the PS-to-core command word protocol (pdh_cmd_master / pdh_core).
// Holds command codes, response status codes, word bit positions and the command-word packer.
package pdh_pkg;

  typedef enum logic [3:0] {
    CMD_IDLE    = 4'd0,
    CMD_SET_LED = 4'd1,
    CMD_SET_DAC = 4'd2
  } cmd_t;

  typedef enum logic [1:0] {
    STS_OK       = 2'd0,
    STS_TIMEOUT  = 2'd1,
    STS_MISMATCH = 2'd2
  } status_t;

  // Command word (to core)
  localparam int CMD_RST_BIT  = 31;
  localparam int CMD_STB_BIT  = 30;
  localparam int CMD_CODE_MSB = 29;
  localparam int CMD_CODE_LSB = 26;
  localparam int CMD_DATA_W   = 26;

  // Callback word (from core)
  localparam int CB_CMD_MSB   = 31;
  localparam int CB_CMD_LSB   = 28;
  localparam int CB_STB_BIT   = 27;
  localparam int CB_PAYLOAD_W = 27;

  function automatic logic [31:0] pack_cmd(input logic rst_b, input logic stb_b,
                                           input logic [3:0] code,
                                           input logic [CMD_DATA_W-1:0] data);
    return {rst_b, stb_b, code, data};
  endfunction

endpackage

// File: rtl/pdh_cmd_timer.sv
// Up-counter cleared by load_i, saturating at all-ones; done_o once the count reaches limit_i.
// Count is 0 in the cycle after load, so limit_i = N-1 flags the N-th cycle of a phase.
module pdh_cmd_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] limit_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)          cnt_d = '0;
    else if (~&cnt_q)    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q >= limit_i);

endmodule

// File: rtl/pdh_cmd_master.sv
// Command-word initiator for pdh_core: setup / strobe / release handshake, one response per command,
// no response backpressure. Optional core reset pulse sequence under PDH_CMD_MASTER_RST_PULSE_EN.
module pdh_cmd_master
  import pdh_pkg::*;
#(
  parameter int SETUP_CYCLES   = 5,
  parameter int HOLD_CYCLES    = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RST_CYCLES     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [3:0]  cmd_i,
  input  logic [25:0] data_i,
`ifdef PDH_CMD_MASTER_RST_PULSE_EN
  input  logic        core_rst_req_i,
`endif
  output logic [31:0] axi_to_core_o,
  input  logic [31:0] axi_from_core_i,
  output logic        rsp_valid_o,
  output logic [1:0]  rsp_status_o,
  output logic [26:0] rsp_payload_o,
  output logic        busy_o
);

  localparam int MAX_A = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_B = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;
`ifdef PDH_CMD_MASTER_RST_PULSE_EN
  localparam logic [2:0] S_RST_ASSERT  = 3'd5;
  localparam logic [2:0] S_RST_RELEASE = 3'd6;
`endif

  logic [2:0]              state_q, state_d;
  cmd_t                    cmd_q, cmd_d;
  logic [25:0]             data_q, data_d;
  status_t                 status_q, status_d;
  logic [26:0]             payload_q, payload_d;
  logic                    ld_hold, ld_to, hold_done, to_done;
  logic [CNT_W-1:0]        hold_lim;

  logic                    cb_stb;
  logic [3:0]              cb_cmd;
  logic [CB_PAYLOAD_W-1:0] cb_payload;

  assign cb_stb     = axi_from_core_i[CB_STB_BIT];
  assign cb_cmd     = axi_from_core_i[CB_CMD_MSB:CB_CMD_LSB];
  assign cb_payload = axi_from_core_i[CB_PAYLOAD_W-1:0];

  // One timer paces every phase; its limit follows the phase it is timing.
  always_comb begin
    hold_lim = CNT_W'(SETUP_CYCLES - 1);
    if (state_q == S_STROBE) hold_lim = CNT_W'(HOLD_CYCLES - 1);
`ifdef PDH_CMD_MASTER_RST_PULSE_EN
    if (state_q == S_RST_ASSERT || state_q == S_RST_RELEASE) hold_lim = CNT_W'(RST_CYCLES - 1);
`endif
  end

  pdh_cmd_timer #(.W(CNT_W)) u_hold_tmr (
    .clk(clk), .rst(rst), .load_i(ld_hold), .limit_i(hold_lim), .done_o(hold_done)
  );

  pdh_cmd_timer #(.W(CNT_W)) u_to_tmr (
    .clk(clk), .rst(rst), .load_i(ld_to), .limit_i(CNT_W'(TIMEOUT_CYCLES - 1)), .done_o(to_done)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    status_d  = status_q;
    payload_d = payload_q;
    ld_hold   = 1'b0;
    ld_to     = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef PDH_CMD_MASTER_RST_PULSE_EN
        if (core_rst_req_i) begin
          status_d = STS_OK;
          ld_hold  = 1'b1;
          state_d  = S_RST_ASSERT;
        end else
`endif
        if (cmd_valid_i) begin
          cmd_d    = cmd_t'(cmd_i);
          data_d   = data_i;
          status_d = STS_OK;
          ld_hold  = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (hold_done) begin
          ld_hold = 1'b1;
          ld_to   = 1'b1;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (to_done) begin
          status_d  = STS_TIMEOUT;
          payload_d = cb_payload;
          state_d   = S_RESP;
        end else if (hold_done && cb_stb) begin
          if (cb_cmd != cmd_q) status_d = STS_MISMATCH;
          ld_hold = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Timeout wins even over a mismatch already recorded during STROBE.
        if (to_done) begin
          status_d  = STS_TIMEOUT;
          payload_d = cb_payload;
          state_d   = S_RESP;
        end else if (hold_done && !cb_stb) begin
          payload_d = cb_payload;
          state_d   = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
`ifdef PDH_CMD_MASTER_RST_PULSE_EN
      S_RST_ASSERT: begin
        if (hold_done) begin
          ld_hold = 1'b1;
          state_d = S_RST_RELEASE;
        end
      end
      S_RST_RELEASE: begin
        if (hold_done) begin
          payload_d = cb_payload;
          state_d   = S_RESP;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= CMD_IDLE;
      data_q    <= '0;
      status_q  <= STS_OK;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      status_q  <= status_d;
      payload_q <= payload_d;
    end
  end

  always_comb begin
    axi_to_core_o = '0;
    case (state_q)
      S_SETUP, S_RELEASE: axi_to_core_o = pack_cmd(1'b0, 1'b0, cmd_q, data_q);
      S_STROBE:           axi_to_core_o = pack_cmd(1'b0, 1'b1, cmd_q, data_q);
`ifdef PDH_CMD_MASTER_RST_PULSE_EN
      S_RST_ASSERT:       axi_to_core_o = pack_cmd(1'b1, 1'b0, CMD_IDLE, '0);
`endif
      default:            axi_to_core_o = '0;
    endcase
  end

  assign cmd_ready_o   = (state_q == S_IDLE) && !rst;
  assign busy_o        = (state_q != S_IDLE);
  assign rsp_valid_o   = (state_q == S_RESP);
  assign rsp_status_o  = status_q;
  assign rsp_payload_o = payload_q;

endmodule

// File: tb/tb_pdh_cmd_master.sv
// Directed bench for pdh_cmd_master with a behavioural core stub (normal echo / no echo / wrong-cmd echo).
module tb_pdh_cmd_master;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_NOECHO = 1;
  localparam int MODE_BADCMD = 2;

  logic        clk, rst;
  logic        cmd_valid_i, cmd_ready_o;
  logic [3:0]  cmd_i;
  logic [25:0] data_i;
  logic [31:0] axi_to_core_o, axi_from_core_i;
  logic        rsp_valid_o, busy_o;
  logic [1:0]  rsp_status_o;
  logic [26:0] rsp_payload_o;

  int n_vec = 0;
  int n_bad = 0;
  int core_mode = MODE_NORMAL;

  pdh_cmd_master #(
    .SETUP_CYCLES(5), .HOLD_CYCLES(5), .TIMEOUT_CYCLES(32), .RST_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_i(cmd_i), .data_i(data_i),
`ifdef PDH_CMD_MASTER_RST_PULSE_EN
    .core_rst_req_i(1'b0),
`endif
    .axi_to_core_o(axi_to_core_o), .axi_from_core_i(axi_from_core_i),
    .rsp_valid_o(rsp_valid_o), .rsp_status_o(rsp_status_o),
    .rsp_payload_o(rsp_payload_o), .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core stub: registered callback, executes SET_LED on the strobe rising edge.
  logic [7:0] led_q;
  logic       prev_stb_q;
  always @(posedge clk) begin
    if (rst) begin
      axi_from_core_i <= '0;
      led_q           <= '0;
      prev_stb_q      <= 1'b0;
    end else begin
      prev_stb_q <= axi_to_core_o[30];
      if (axi_to_core_o[30] && !prev_stb_q && axi_to_core_o[29:26] == 4'd1)
        led_q <= axi_to_core_o[7:0];
      case (core_mode)
        MODE_NOECHO: axi_from_core_i <= {axi_to_core_o[29:26], 1'b0, 1'b0, axi_to_core_o[25:0]};
        MODE_BADCMD: axi_from_core_i <= {4'd2, axi_to_core_o[30], 27'h0};
        default:     axi_from_core_i <= {axi_to_core_o[29:26], axi_to_core_o[30], 1'b0, axi_to_core_o[25:0]};
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  cmd;
    logic [25:0] data;
    int          mode;
    logic [1:0]  st;
    logic [26:0] pl;
    int          n_setup;
    int          n_stb;
    int          n_rel;
    logic [7:0]  led;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int setup_n, stb_n, rel_n, rsp_n, other_n, w;
    bit seen_stb, done;
    logic [1:0]  st;
    logic [26:0] pl;
    logic [31:0] rsp_word, base;
    setup_n = 0; stb_n = 0; rel_n = 0; rsp_n = 0; other_n = 0;
    seen_stb = 0; done = 0; st = '0; pl = '0; rsp_word = '0;
    base = {2'b00, v.cmd, v.data};
    core_mode = v.mode;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_i = v.cmd; data_i = v.data;
    w = 0;
    while (!cmd_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", {31'b0, cmd_ready_o}, 32'd1);
    @(negedge clk);
    cmd_valid_i = 1'b0; cmd_i = 4'hF; data_i = 26'h2A5A5A5;
    for (int c = 0; c < 200 && !done; c++) begin
      if (rsp_valid_o) begin
        rsp_n++; done = 1; st = rsp_status_o; pl = rsp_payload_o; rsp_word = axi_to_core_o;
      end else if (axi_to_core_o == (base | 32'h4000_0000)) begin
        seen_stb = 1; stb_n++;
      end else if (axi_to_core_o == base) begin
        if (seen_stb) rel_n++;
        else setup_n++;
      end else begin
        other_n++;
      end
      if (!done) @(negedge clk);
    end
    chk("rsp_seen", {31'b0, done}, 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid_o) rsp_n++;
    end
    chk("status", {30'b0, st}, {30'b0, v.st});
    chk("payload", {5'b0, pl}, {5'b0, v.pl});
    chk("setup_cycles", setup_n, v.n_setup);
    chk("strobe_cycles", stb_n, v.n_stb);
    chk("release_cycles", rel_n, v.n_rel);
    chk("stray_words", other_n, 0);
    chk("word_in_resp", rsp_word, 32'h0);
    chk("rsp_count", rsp_n, 1);
    chk("led", {24'b0, led_q}, {24'b0, v.led});
    chk("idle_word", axi_to_core_o, 32'h0);
  endtask

  vec_t vt[6];

  initial begin
    int w, rsp_n, acc_n, rsp1_c, acc2_c, rdy_busy;
    logic [26:0] pl1, pl2;
    vec_t v;

    vt[0] = '{4'd1, 26'h0000055, MODE_NORMAL, 2'd0, 27'h0000055, 5, 5,  5, 8'h55};
    vt[1] = '{4'd2, 26'h0000123, MODE_NORMAL, 2'd0, 27'h0000123, 5, 5,  5, 8'h55};
    vt[2] = '{4'd1, 26'h3FFFFFF, MODE_NORMAL, 2'd0, 27'h3FFFFFF, 5, 5,  5, 8'hFF};
    vt[3] = '{4'd1, 26'h00002AA, MODE_NOECHO, 2'd1, 27'h00002AA, 5, 32, 0, 8'hAA};
    vt[4] = '{4'd1, 26'h0000011, MODE_BADCMD, 2'd2, 27'h0000000, 5, 5,  5, 8'h11};
    vt[5] = '{4'd0, 26'h0000001, MODE_NORMAL, 2'd0, 27'h0000001, 5, 5,  5, 8'h11};

    rst = 1'b1; cmd_valid_i = 1'b0; cmd_i = '0; data_i = '0;
    repeat (10) @(negedge clk);
    chk("ready_in_reset", {31'b0, cmd_ready_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_word", axi_to_core_o, 32'h0);
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("reset_status", {30'b0, rsp_status_o}, 32'd0);
    chk("reset_payload", {5'b0, rsp_payload_o}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Reset while strobe is high: in-flight command dropped silently.
    core_mode = MODE_NORMAL;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_i = 4'd1; data_i = 26'h77;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    w = 0;
    while (!axi_to_core_o[30] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("midstb_reached", {31'b0, axi_to_core_o[30]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midstb_word", axi_to_core_o, 32'h0);
    chk("midstb_busy", {31'b0, busy_o}, 32'd0);
    rst = 1'b0;
    rsp_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid_o) rsp_n++;
      @(negedge clk);
    end
    chk("midstb_no_rsp", rsp_n, 0);
    v = '{4'd2, 26'h0000123, MODE_NORMAL, 2'd0, 27'h0000123, 5, 5, 5, 8'h00};
    run_vec(v);

    // Two queued commands with valid held high.
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_i = 4'd1; data_i = 26'h1;
    rsp_n = 0; acc_n = 0; rsp1_c = -1; acc2_c = -1; rdy_busy = 0; pl1 = '0; pl2 = '0;
    for (int c = 0; c < 200 && rsp_n < 2; c++) begin
      if (busy_o && cmd_ready_o) rdy_busy++;
      if (rsp_valid_o) begin
        rsp_n++;
        if (rsp_n == 1) begin rsp1_c = c; pl1 = rsp_payload_o; end
        else pl2 = rsp_payload_o;
      end
      if (cmd_valid_i && cmd_ready_o) begin
        acc_n++;
        if (acc_n == 2) acc2_c = c;
      end else if (acc_n == 1) begin
        data_i = 26'h2;
      end else if (acc_n == 2) begin
        cmd_valid_i = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid_i = 1'b0;
    chk("b2b_rsp_count", rsp_n, 2);
    chk("b2b_accepts", acc_n, 2);
    chk("b2b_second_accept", acc2_c, rsp1_c + 1);
    chk("b2b_ready_while_busy", rdy_busy, 0);
    chk("b2b_payload1", {5'b0, pl1}, 32'h1);
    chk("b2b_payload2", {5'b0, pl2}, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pdh_cmd_master.md
Name: pdh_cmd_master

Overview:
- Initiator end of the PS-to-core command word protocol: drives the 32-bit command word into pdh_core and reads its 32-bit callback word.
- Runs the two-step strobe handshake: setup, strobe high, strobe low.
- Takes commands from a valid/ready queue and returns one response per command with status and callback payload.
- Used for PL-side sequencing (scan/lock scripts) and as the reusable bench driver for pdh_core.

Parameters:
- SETUP_CYCLES, 5: cycles the word is held with strobe=0 before strobe rises; also the minimum low-hold after strobe falls.
- HOLD_CYCLES, 5: minimum cycles strobe stays high.
- TIMEOUT_CYCLES, 1024: maximum cycles spent waiting for the callback in STROBE or RELEASE.
- RST_CYCLES, 10: core reset pulse length (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_i  in  4  command code (cmd_t)
- data_i  in  26  command payload
- axi_to_core_o  out  32  command word: [31]=rst, [30]=strobe, [29:26]=cmd, [25:0]=data
- axi_from_core_i  in  32  callback word: [31:28]=cmd echo, [27]=strobe echo, [26:0]=payload
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure
- rsp_status_o  out  2  0=OK, 1=TIMEOUT, 2=MISMATCH
- rsp_payload_o  out  27  callback [26:0] captured at completion
- busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: axi_to_core_o=0, rsp_valid_o=0, rsp_status_o=0, rsp_payload_o=0, busy_o=0, state=IDLE.
- cmd_ready_o = (state==IDLE) && !rst.
- IDLE:
  - On valid&ready, latch cmd_i and data_i and go to SETUP.
  - From the next cycle, drive {0,0,cmd,data}.
- SETUP: hold the word with strobe=0 for SETUP_CYCLES cycles, then go to STROBE.
- STROBE:
  - Drive strobe=1 and start the timeout counter.
  - Leave when the hold counter has reached HOLD_CYCLES AND callback[27]==1:
    - If callback[31:28]==latched cmd, go to RELEASE.
    - Otherwise set status MISMATCH and go to RELEASE.
  - Before HOLD_CYCLES elapses, callback contents are ignored.
- RELEASE:
  - Drive strobe=0, keeping cmd and data.
  - Leave when callback[27]==0 AND at least SETUP_CYCLES have elapsed.
  - Capture callback[26:0] into rsp_payload_o and go to RESP.
- RESP:
  - rsp_valid_o=1 for exactly this cycle.
  - Word returns to 0.
  - Next state is IDLE, so back-to-back commands are spaced by at least 1 idle cycle.
- Timeout:
  - The counter resets on entry to STROBE and keeps running through RELEASE.
  - When it reaches TIMEOUT_CYCLES: status=TIMEOUT, payload=current callback[26:0], go to RESP.
  - TIMEOUT overrides MISMATCH.
- Counters are unsigned and saturating. Width is $clog2(max parameter)+1. No wrap-around.
- rst in any state:
  - Next cycle: state=IDLE and all outputs at their reset values.
  - The in-flight command is discarded with no rsp_valid_o.
- cmd_valid_i and cmd_i are ignored while busy. Data is latched only on handshake.

Optional Feature:
PDH_CMD_MASTER_RST_PULSE_EN
- With the macro:
  - Adds port core_rst_req_i (in, 1).
  - In IDLE, core_rst_req_i has priority over cmd_valid_i.
  - Sequence: RST_ASSERT drives 0x80000000 for RST_CYCLES, then RST_RELEASE drives 0 for RST_CYCLES, then RESP with status OK and payload = callback[26:0].
- Without the macro: the port is absent, bit 31 is constant 0, and the RST states do not exist.

Decomposition:
- pdh_pkg holds:
  - cmd_t (CMD_IDLE=0, CMD_SET_LED=1, CMD_SET_DAC=2)
  - status_t
  - localparam bit positions for both words
  - a pack function for the command word
- pdh_pkg is shared with pdh_core.
- One sub-module, pdh_cmd_timer: loadable counter with saturate and a done flag. Instantiated twice (hold/setup, timeout).

Test Plan:
- Reset 10 cycles, then release: axi_to_core_o==0, busy_o==0, cmd_ready_o==1 on the first post-reset cycle.
- SET_LED 0x55 against real pdh_core:
  - Word sequence: 0x04000055 for 5 cycles, then 0x44000055 for at least 5 cycles, then 0x04000055, then 0.
  - One rsp_valid_o with status OK, rsp_payload_o[7:0]==0x55, led_o==0x55.
- TIMEOUT_CYCLES=32 with a stub that never echoes strobe: rsp status TIMEOUT exactly 32 cycles after STROBE entry; word returns to 0.
- Stub echoes cmd=2 with [27]=1 for a SET_LED command: status MISMATCH; strobe still drops; exactly one response.
- rst asserted mid-STROBE: next cycle axi_to_core_o==0, no rsp_valid_o ever; a following SET_DAC 0x123 completes OK.
- cmd_valid_i held high with two queued commands: second accepted only in the IDLE cycle after the first RESP; cmd_ready_o low throughout busy.
